// File: rtl/adpll_error_monitor.sv
// ADPLL phase-error monitor: running min/max/count stats, lock detection with
// hysteresis, and a one-shot capture buffer drained over a valid/ready port.
module adpll_error_monitor #(
    parameter int ERR_WIDTH   = 8,
    parameter int DEPTH       = 16,
    parameter int LOCK_THRESH = 4,
    parameter int LOCK_COUNT  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_ni,
    input  logic                 enable_i,
    input  logic                 sample_i,
    input  logic [ERR_WIDTH-1:0] error_i,
    input  logic                 clear_stats_i,
    input  logic                 arm_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [ERR_WIDTH-1:0] rd_data_o,
    output logic                 busy_o,
    output logic                 capture_done_o,
    output logic                 locked_o,
    output logic                 stats_valid_o,
    output logic [ERR_WIDTH-1:0] err_min_o,
    output logic [ERR_WIDTH-1:0] err_max_o,
    output logic [CNT_WIDTH-1:0] sample_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ERR_WIDTH-1:0] ERR_POS_MAX = {1'b0, {(ERR_WIDTH-1){1'b1}}};
    localparam logic [ERR_WIDTH-1:0] ERR_NEG_MAX = {1'b1, {(ERR_WIDTH-1){1'b0}}};
    localparam logic [ERR_WIDTH+1:0] THR_IN  = (ERR_WIDTH+2)'(LOCK_THRESH);
    localparam logic [ERR_WIDTH+1:0] THR_OUT = (ERR_WIDTH+2)'(2 * LOCK_THRESH);
    localparam logic [7:0] RUN_MAX = 8'(LOCK_COUNT);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                state;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [7:0]            run_cnt;
    logic [ERR_WIDTH-1:0]  mem [DEPTH];

    logic                  accept;
    logic [ERR_WIDTH-1:0]  abs_err;
    logic [ERR_WIDTH+1:0]  abs_ext;

    assign accept  = sample_i & enable_i;
    // Unsigned magnitude: the most negative code maps to 2^(ERR_WIDTH-1) exactly.
    assign abs_err = error_i[ERR_WIDTH-1] ? -error_i : error_i;
    assign abs_ext = {2'b00, abs_err};

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni || clear_stats_i) begin
            err_min_o      <= ERR_POS_MAX;
            err_max_o      <= ERR_NEG_MAX;
            sample_count_o <= '0;
            stats_valid_o  <= 1'b0;
        end else if (accept) begin
            if ($signed(error_i) < $signed(err_min_o)) err_min_o <= error_i;
            if ($signed(error_i) > $signed(err_max_o)) err_max_o <= error_i;
            if (sample_count_o != '1) sample_count_o <= sample_count_o + CNT_WIDTH'(1);
            stats_valid_o <= 1'b1;
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni) begin
            run_cnt  <= '0;
            locked_o <= 1'b0;
        end else if (accept) begin
            if (abs_ext <= THR_IN) begin
                if (run_cnt < RUN_MAX) run_cnt <= run_cnt + 8'd1;
                if (run_cnt >= RUN_MAX - 8'd1) locked_o <= 1'b1;
            end else begin
                // Middle band resets the run but keeps an existing lock.
                run_cnt <= '0;
                if (abs_ext > THR_OUT) locked_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge fpga_clk_i) begin
        if (state == FILL && accept) mem[wr_ptr] <= error_i;
    end

    always_ff @(posedge fpga_clk_i) begin
        if (!reset_ni) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rd_valid_o     <= 1'b0;
            rd_data_o      <= '0;
            busy_o         <= 1'b0;
            capture_done_o <= 1'b0;
        end else begin
            capture_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        state  <= FILL;
                        wr_ptr <= '0;
                        busy_o <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        if (wr_ptr == LAST) begin
                            // Entry 0 was written long before the last one lands.
                            state      <= DRAIN;
                            rd_ptr     <= '0;
                            rd_valid_o <= 1'b1;
                            rd_data_o  <= mem[0];
                        end
                    end
                end
                DRAIN: begin
                    if (rd_ready_i) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        if (rd_ptr == LAST) begin
                            rd_valid_o     <= 1'b0;
                            capture_done_o <= 1'b1;
                            busy_o         <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            rd_data_o <= mem[rd_ptr + PW'(1)];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adpll_error_monitor.sv
// Directed bench for adpll_error_monitor; capture reads are checked by a
// scoreboard monitor against values queued when the samples are issued.
module tb_adpll_error_monitor;
    logic        fpga_clk_i = 1'b0;
    logic        reset_ni, enable_i, sample_i, clear_stats_i, arm_i, rd_ready_i;
    logic [7:0]  error_i;
    logic        rd_valid_o, busy_o, capture_done_o, locked_o, stats_valid_o;
    logic [7:0]  rd_data_o, err_min_o, err_max_o;
    logic [15:0] sample_count_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] exp_q [$];

    int         m_cnt;
    logic [7:0] m_min, m_max;
    logic       m_valid;

    adpll_error_monitor dut (
        .fpga_clk_i(fpga_clk_i), .reset_ni(reset_ni), .enable_i(enable_i),
        .sample_i(sample_i), .error_i(error_i), .clear_stats_i(clear_stats_i),
        .arm_i(arm_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o),
        .rd_data_o(rd_data_o), .busy_o(busy_o), .capture_done_o(capture_done_o),
        .locked_o(locked_o), .stats_valid_o(stats_valid_o), .err_min_o(err_min_o),
        .err_max_o(err_max_o), .sample_count_o(sample_count_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge fpga_clk_i) begin
        if (rd_valid_o === 1'b1) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_valid_o), 32'd0);
            else if (rd_ready_i) chk("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
            else chk("rd_stall", 32'(rd_data_o), 32'(exp_q[0]));
        end
        if (capture_done_o === 1'b1) begin
            done_cnt++;
            chk("done_busy", 32'(busy_o), 32'd0);
        end
    end

    task automatic tick();
        @(posedge fpga_clk_i);
        #1;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_min = 8'h7F; m_max = 8'h80; m_valid = 1'b0;
    endtask

    task automatic model_acc(input logic [7:0] e);
        m_cnt++;
        if ($signed(e) < $signed(m_min)) m_min = e;
        if ($signed(e) > $signed(m_max)) m_max = e;
        m_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] e, input logic en);
        enable_i = en; sample_i = 1'b1; error_i = e;
        tick();
        sample_i = 1'b0; enable_i = 1'b1;
        if (en) model_acc(e);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_min"},   32'(err_min_o), 32'(m_min));
        chk({tag, "_max"},   32'(err_max_o), 32'(m_max));
        chk({tag, "_count"}, 32'(sample_count_o), 32'(m_cnt));
        chk({tag, "_valid"}, 32'(stats_valid_o), 32'(m_valid));
    endtask

    task automatic drain(input string tag, input int budget, input logic toggle);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
            rd_ready_i = toggle ? ((c % 2) == 0) : 1'b1;
            arm_i      = toggle && (c == 4);
            sample_i   = toggle && (c == 6);
            enable_i   = 1'b1;
            error_i    = 8'd1;
            tick();
            if (toggle && c == 6) model_acc(8'd1);
        end
        arm_i = 1'b0; sample_i = 1'b0; rd_ready_i = 1'b0;
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done"}, 32'(capture_done_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(capture_done_o), 32'd0);
    endtask

    initial begin
        reset_ni = 1'b0; enable_i = 1'b1; sample_i = 1'b1; error_i = 8'h33;
        clear_stats_i = 1'b0; arm_i = 1'b1; rd_ready_i = 1'b1;
        repeat (3) tick();
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(capture_done_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_rd_data", 32'(rd_data_o), 32'd0);
        model_reset();
        chk_stats("rst");
        reset_ni = 1'b1; sample_i = 1'b0; arm_i = 1'b0; rd_ready_i = 1'b0;
        tick();

        send(8'd5, 1'b1); send(-8'sd12, 1'b1); send(8'd20, 1'b1); send(8'h80, 1'b1);
        chk("stats_min", 32'(err_min_o), 32'h80);
        chk("stats_max", 32'(err_max_o), 32'd20);
        chk("stats_count", 32'(sample_count_o), 32'd4);
        chk("stats_valid", 32'(stats_valid_o), 32'd1);
        clear_stats_i = 1'b1;
        send(8'd7, 1'b1);
        clear_stats_i = 1'b0;
        model_reset();
        chk_stats("clear");

        for (int i = 0; i < 31; i++) send(8'd3, 1'b1);
        chk("lock_31", 32'(locked_o), 32'd0);
        send(8'd3, 1'b1);
        chk("lock_32", 32'(locked_o), 32'd1);
        send(-8'sd100, 1'b0);
        chk("lock_disabled", 32'(locked_o), 32'd1);
        send(8'd6, 1'b1);
        chk("lock_mid_band", 32'(locked_o), 32'd1);
        send(-8'sd9, 1'b1);
        chk("lock_drop", 32'(locked_o), 32'd0);
        for (int i = 0; i < 31; i++) send(8'd0, 1'b1);
        chk("relock_31", 32'(locked_o), 32'd0);
        send(8'd0, 1'b1);
        chk("relock_32", 32'(locked_o), 32'd1);
        chk_stats("lock");

        // Sample coincident with arm is not captured.
        arm_i = 1'b1; sample_i = 1'b1; enable_i = 1'b1; error_i = 8'd99;
        tick();
        arm_i = 1'b0; sample_i = 1'b0;
        model_acc(8'd99);
        chk("arm_busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < 3; i++) begin exp_q.push_back(8'(i)); send(8'(i), 1'b1); end
        send(8'd77, 1'b0);
        chk("fill_disabled_count", 32'(sample_count_o), 32'(m_cnt));
        for (int i = 3; i < 16; i++) begin exp_q.push_back(8'(i)); send(8'(i), 1'b1); end
        chk("drain_valid", 32'(rd_valid_o), 32'd1);
        chk("drain_busy", 32'(busy_o), 32'd1);
        drain("cap1", 200, 1'b1);
        repeat (3) tick();
        chk("post_drain_busy", 32'(busy_o), 32'd0);
        chk_stats("cap1");

        arm_i = 1'b1; tick(); arm_i = 1'b0;
        for (int i = 0; i < 7; i++) send(8'(50 + i), 1'b1);
        chk("fill7_busy", 32'(busy_o), 32'd1);
        reset_ni = 1'b0; tick(); reset_ni = 1'b1;
        model_reset();
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_valid", 32'(rd_valid_o), 32'd0);
        arm_i = 1'b1; tick(); arm_i = 1'b0;
        for (int i = 0; i < 16; i++) begin exp_q.push_back(8'(100 + i)); send(8'(100 + i), 1'b1); end
        drain("cap2", 100, 1'b0);
        chk_stats("cap2");
        chk("done_count", 32'(done_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adpll_error_monitor.md
Name: adpll_error_monitor

Overview:
- Synthesizable on-chip successor to the ADPLL bench-side error logging. It runs in the fpga_clk_i domain beside the ADPLL.
- It samples the signed phase error once per reference strobe and tracks running min/max with a sample count.
- It flags lock with hysteresis, and captures a parametrised-depth window of error samples into a buffer that is drained through a valid/ready port (to UART/ILA/display).

Parameters:
- ERR_WIDTH, 8, width of signed phase error.
- DEPTH, 16, capture buffer depth (power of 2, 2..256).
- LOCK_THRESH, 4, |error| <= this counts as in-lock sample.
- LOCK_COUNT, 32, consecutive in-lock samples required to assert locked_o (1..255).
- CNT_WIDTH, 16, width of saturating sample counter.

Ports:
- fpga_clk_i, in, 1, system clock (258 MHz class).
- reset_ni, in, 1, synchronous active-low reset.
- enable_i, in, 1, when 0 sample_i is ignored.
- sample_i, in, 1, one-cycle strobe: error_i valid this cycle.
- error_i, in, ERR_WIDTH, signed phase error.
- clear_stats_i, in, 1, clears min/max/count/stats_valid_o.
- arm_i, in, 1, pulse: start a capture.
- rd_ready_i, in, 1, consumer ready.
- rd_valid_o, out, 1, rd_data_o valid.
- rd_data_o, out, ERR_WIDTH, captured sample (signed, oldest first).
- busy_o, out, 1, capture in FILL or DRAIN.
- capture_done_o, out, 1, one-cycle pulse after last sample drained.
- locked_o, out, 1, lock indicator.
- stats_valid_o, out, 1, at least one sample since reset/clear.
- err_min_o, out, ERR_WIDTH, minimum signed error seen.
- err_max_o, out, ERR_WIDTH, maximum signed error seen.
- sample_count_o, out, CNT_WIDTH, accepted samples, saturates at all-ones.

Behaviour:
- Accepted sample = sample_i & enable_i.
- Reset (reset_ni=0 at a clock edge):
  - rd_valid_o=0, busy_o=0, capture_done_o=0, locked_o=0, stats_valid_o=0, sample_count_o=0, rd_data_o=0.
  - err_min_o = most positive (0x7F), err_max_o = most negative (0x80).
  - FSM=IDLE, lock run counter=0.
  - Reset mid-capture discards the buffer.
- Stats (1-cycle latency: outputs reflect a sample on the edge after its strobe):
  - err_min_o/err_max_o updated by signed compare.
  - sample_count_o += 1, saturating at all-ones.
  - stats_valid_o set on the first accepted sample.
- clear_stats_i:
  - Restores stat reset values. Does not affect lock or capture.
  - If asserted together with an accepted sample, clear wins and that sample is dropped from the stats.
- Lock, with |e| computed unsigned in ERR_WIDTH bits (most negative value maps to 2^(ERR_WIDTH-1), no overflow):
  - |e| <= LOCK_THRESH: run counter +1, saturating at LOCK_COUNT. locked_o=1 on the edge where the counter reaches LOCK_COUNT.
  - LOCK_THRESH < |e| <= 2*LOCK_THRESH: run counter=0, locked_o holds.
  - |e| > 2*LOCK_THRESH: run counter=0, locked_o=0.
- Capture FSM:
  - IDLE:
    - arm_i goes to FILL with write pointer=0.
    - arm_i while busy is ignored.
  - FILL:
    - Each accepted sample is written at wr_ptr and wr_ptr increments.
    - After the DEPTH-th write, go to DRAIN with rd_ptr=0.
    - A sample coincident with arm_i in IDLE is not captured; capture starts with the next accepted sample.
  - DRAIN:
    - rd_valid_o=1 and rd_data_o=buf[rd_ptr]. Data is registered and stable while rd_valid_o & ~rd_ready_i.
    - On rd_valid_o & rd_ready_i, rd_ptr increments.
    - On the transfer of the DEPTH-th sample: rd_valid_o=0 next cycle, capture_done_o pulses for 1 cycle, return to IDLE.
    - Samples arriving during DRAIN are not captured; stats and lock still update.
  - busy_o=1 in FILL and DRAIN.
- Pointers are $clog2(DEPTH) bits and wrap naturally. The buffer is inferred as distributed RAM (no reset on contents).

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles with strobes active -> all outputs at reset values, err_min_o=0x7F, err_max_o=0x80, sample_count_o=0.
- Stats: samples +5, -12, +20, -128 -> err_min_o=-128, err_max_o=+20, sample_count_o=4, stats_valid_o=1. clear_stats_i together with the next sample -> count=0, stats_valid_o=0.
- Lock hysteresis (defaults):
  - 32 samples of +3 -> locked_o=1 one cycle after the 32nd.
  - One sample of +6 -> still locked.
  - One sample of -9 -> locked_o=0.
  - 31 samples of 0 -> still 0.
- Capture with backpressure: arm, feed 0..15, rd_ready_i toggled 1/0 -> 16 reads 0..15 in order, data stable while stalled, capture_done_o single pulse after read 15, busy_o falls the same cycle.
- Boundaries:
  - arm_i during DRAIN is ignored.
  - enable_i=0 strobes are ignored in FILL, stats and lock.
  - Reset asserted after 7 FILL samples -> busy_o=0, rd_valid_o=0, a fresh arm captures new data only.
